regfile_wb_scheduler: RTL and testbench

//   Shares the register file's single write port among NREQ writeback requesters (ALU, LSU, debug).

---
 rtl/regfile_wb_scheduler.sv | 144 ++++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler
//   Shares the single register-file write port among NREQ writeback requesters.
//   A round-robin arbiter issues a one-hot ready. The winning write is registered
//   toward the RegistersUnit with a latency of one cycle.
//   A busy scoreboard tracks registers that still have an outstanding producer.
//   Decode sets a register busy at issue, and the writeback handshake clears it.
//   Decode queries the scoreboard through rs1/rs2 and the stall output.
module regfile_wb_scheduler #(
    parameter int NREQ = 3,
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*AW-1:0]        req_rd,
    input  logic [NREQ*XLEN-1:0]      req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      issue_valid,
    input  logic [AW-1:0]             issue_rd,
    input  logic [AW-1:0]             rs1,
    input  logic [AW-1:0]             rs2,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic                      stall,
    output logic                      rf_wr,
    output logic [AW-1:0]             rf_rd,
    output logic [XLEN-1:0]           rf_data,
    output logic [$clog2(NREQ)-1:0]   grant_id
);

    localparam int PW = $clog2(NREQ);
    localparam int NR = 2**AW;

    logic [PW-1:0]   r_rr_ptr;
    logic [NR-1:0]   r_busy;
    logic            r_rf_wr;
    logic [AW-1:0]   r_rf_rd;
    logic [XLEN-1:0] r_rf_data;
    logic [PW-1:0]   r_grant_id;

    logic            w_found_hi;
    logic            w_found_any;
    logic [PW-1:0]   w_idx_hi;
    logic [PW-1:0]   w_idx_any;
    logic [PW-1:0]   w_grant_idx;
    logic [PW-1:0]   w_rr_next;
    logic            w_hs;
    logic [NREQ-1:0] w_ready;
    logic [AW-1:0]   w_sel_rd;
    logic [XLEN-1:0] w_sel_data;
    logic            w_sel_nonzero;
    logic [NR-1:0]   w_set_mask;
    logic [NR-1:0]   w_clr_mask;

    // Round-robin pick. Take the lowest valid index at or above rr_ptr.
    // If none exists there, wrap around to the lowest valid index overall.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_found_hi  = 1'b0;
        w_found_any = 1'b0;
        w_idx_hi    = '0;
        w_idx_any   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_found_any = 1'b1;
                w_idx_any   = PW'(i);
                if (PW'(i) >= r_rr_ptr) begin
                    w_found_hi = 1'b1;
                    w_idx_hi   = PW'(i);
                end
            end
        end
        w_grant_idx = w_found_hi ? w_idx_hi : w_idx_any;
    end

    // Build the one-hot ready and mux the winning requester's rd/data.
    always_comb begin
        w_ready    = '0;
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (PW'(i) == w_grant_idx) begin
                w_ready[i] = w_found_any;
                w_sel_rd   = req_rd[i*AW +: AW];
                w_sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // Ready always implies valid, so any found requester completes its handshake this cycle.
    assign w_hs          = w_found_any;
    assign w_sel_nonzero = (w_sel_rd != '0);
    assign w_rr_next     = (w_grant_idx == PW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;

    // Ready is held low during reset, so the requester sees that a reset-cycle handshake did not happen.
    assign req_ready = w_ready & {NREQ{Rst_n}};

    // Scoreboard masks. In the update, set is applied after clear so that a new issue wins over a same-cycle commit.
    assign w_set_mask = issue_valid ? (NR'(1) << issue_rd) : '0;
    assign w_clr_mask = w_hs        ? (NR'(1) << w_sel_rd) : '0;

    // Arbiter pointer and registered write drive toward the register file.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rr_ptr   <= '0;
            r_rf_wr    <= 1'b0;
            r_rf_rd    <= '0;
            r_rf_data  <= '0;
            r_grant_id <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_rf_wr <= w_hs & w_sel_nonzero;
            if (w_hs) begin
                r_rr_ptr   <= w_rr_next;
                r_grant_id <= w_grant_idx;
                if (w_sel_nonzero) begin
                    r_rf_rd   <= w_sel_rd;
                    r_rf_data <= w_sel_data;
                end
            end
        end
    end

    // Busy scoreboard. Bit 0 is forced to zero because x0 never has a producer.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            // NOTE: the scoreboard is a flop vector (not RAM), so resetting it as a whole is legal and intended.
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & ~NR'(1);
        end
    end

    assign rs1_busy = r_busy[rs1];
    assign rs2_busy = r_busy[rs2];
    assign stall    = rs1_busy | rs2_busy;

    assign rf_wr    = r_rf_wr;
    assign rf_rd    = r_rf_rd;
    assign rf_data  = r_rf_data;
    assign grant_id = r_grant_id;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler
//   Directed scenarios followed by randomized requester/decode traffic.
//   A queue-free behavioural model tracks the pointer, the scoreboard and the expected write.
//   Outputs are compared against the model every cycle.
//   Literal expectations pin the directed cases.
module tb_regfile_wb_scheduler;

    localparam int NREQ = 3;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int PW   = $clog2(NREQ);
    localparam int NR   = 2**AW;

    logic                 Clk = 1'b0;
    logic                 Rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_rd;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 issue_valid;
    logic [AW-1:0]        issue_rd;
    logic [AW-1:0]        rs1;
    logic [AW-1:0]        rs2;
    logic                 rs1_busy;
    logic                 rs2_busy;
    logic                 stall;
    logic                 rf_wr;
    logic [AW-1:0]        rf_rd;
    logic [XLEN-1:0]      rf_data;
    logic [PW-1:0]        grant_id;

    regfile_wb_scheduler #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .req_valid   (req_valid),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .stall       (stall),
        .rf_wr       (rf_wr),
        .rf_rd       (rf_rd),
        .rf_data     (rf_data),
        .grant_id    (grant_id)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int              m_ptr;
    bit              m_busy [NR];
    bit              m_wr;
    int              m_rd;
    logic [XLEN-1:0] m_data;
    int              m_gid;
    int              m_last_g;

    // Randomized requester state
    bit              pend  [NREQ];
    logic [AW-1:0]   prd   [NREQ];
    logic [XLEN-1:0] pdata [NREQ];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_wr = 1'b0;
        m_rd = 0;
        m_data = '0;
        m_gid = 0;
        m_last_g = -1;
        for (int r = 0; r < NR; r++) m_busy[r] = 1'b0;
    endtask

    // Round robin: the first valid requester scanning forward from the pointer, modulo NREQ.
    function automatic int model_grant();
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic idle();
        req_valid   = '0;
        issue_valid = 1'b0;
        rs1         = '0;
        rs2         = '0;
    endtask

    // Called at a negedge with the inputs already applied.
    // Compares all outputs against the model, then advances the model across the next rising edge.
    task automatic step();
        int g;
        int rd;
        logic [NREQ-1:0] exp_ready;
        #1;
        g = model_grant();
        exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
        check("req_ready", req_ready, exp_ready);
        check("rf_wr", rf_wr, m_wr);
        if (m_wr) begin
            check("rf_rd", rf_rd, m_rd);
            check("rf_data", rf_data, m_data);
        end
        check("grant_id", grant_id, m_gid);
        check("rs1_busy", rs1_busy, m_busy[rs1]);
        check("rs2_busy", rs2_busy, m_busy[rs2]);
        check("stall", stall, m_busy[rs1] | m_busy[rs2]);
        @(posedge Clk);
        m_last_g = g;
        if (g >= 0) begin
            rd = int'(req_rd[g*AW +: AW]);
            m_ptr = (g + 1) % NREQ;
            m_gid = g;
            m_wr = (rd != 0);
            if (rd != 0) begin
                m_rd = rd;
                m_data = req_data[g*XLEN +: XLEN];
                m_busy[rd] = 1'b0;
            end
        end else begin
            m_wr = 1'b0;
        end
        if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        @(negedge Clk);
    endtask

    initial begin
        Rst_n = 1'b1;
        idle();
        req_rd = '0;
        req_data = '0;
        issue_rd = '0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0;
            prd[i] = '0;
            pdata[i] = '0;
        end

        // Reset with every requester valid: all outputs low immediately.
        req_valid = 3'b111;
        #1 Rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_rf_wr", rf_wr, 0);
        check("rst_rf_rd", rf_rd, 0);
        check("rst_rf_data", rf_data, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_stall", stall, 0);
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        req_valid = '0;

        // Round robin across all three requesters held valid.
        req_valid = 3'b111;
        req_rd = {5'd3, 5'd2, 5'd1};
        req_data = {32'h0000_000C, 32'h0000_000B, 32'h0000_000A};
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_grant_order", grant_id, i % 3);
            check("rr_rf_wr", rf_wr, 1);
        end
        idle();
        step();

        // Single request from requester 1.
        req_valid = 3'b010;
        req_rd[1*AW +: AW] = 5'd7;
        req_data[1*XLEN +: XLEN] = 32'hDEAD_BEEF;
        #1 check("single_ready", req_ready, 3'b010);
        step();
        req_valid = '0;
        check("single_rf_wr", rf_wr, 1);
        check("single_rf_rd", rf_rd, 7);
        check("single_rf_data", rf_data, 32'hDEAD_BEEF);
        check("single_grant_id", grant_id, 1);
        step();
        check("single_rf_wr_drop", rf_wr, 0);

        // A write to x0 completes the handshake but never drives the register file.
        req_valid = 3'b100;
        req_rd[2*AW +: AW] = 5'd0;
        #1 check("x0_ready", req_ready, 3'b100);
        step();
        req_valid = '0;
        check("x0_rf_wr", rf_wr, 0);
        check("x0_grant_id", grant_id, 2);
        req_valid = 3'b111;
        req_rd = {5'd3, 5'd0, 5'd1};
        #1 check("x0_ptr_wrap", req_ready, 3'b001);
        step();
        idle();
        step();

        // Scoreboard set by issue, cleared by the writeback handshake.
        issue_valid = 1'b1;
        issue_rd = 5'd5;
        step();
        issue_valid = 1'b0;
        rs1 = 5'd5;
        #1;
        check("sb_stall_set", stall, 1);
        check("sb_rs1_busy", rs1_busy, 1);
        req_valid = 3'b001;
        req_rd[0 +: AW] = 5'd5;
        req_data[0 +: XLEN] = 32'h0000_0055;
        step();
        req_valid = '0;
        check("sb_stall_clear", stall, 0);
        step();

        // Same-cycle set and clear of x9: the set wins.
        issue_valid = 1'b1;
        issue_rd = 5'd9;
        req_valid = 3'b001;
        req_rd[0 +: AW] = 5'd9;
        step();
        idle();
        rs2 = 5'd9;
        #1;
        check("coll_rs2_busy", rs2_busy, 1);
        check("coll_stall", stall, 1);
        step();

        // Randomized traffic, with a reset asserted mid-run.
        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!pend[i]) begin
                        pend[i] = 1'b1;
                        prd[i] = AW'($urandom_range(1, NR - 1));
                        pdata[i] = $urandom;
                    end
                    req_rd[i*AW +: AW] = prd[i];
                    req_data[i*XLEN +: XLEN] = pdata[i];
                end
                req_valid = 3'b111;
                #2 Rst_n = 1'b0;
                #1;
                check("midrst_rf_wr", rf_wr, 0);
                check("midrst_rf_rd", rf_rd, 0);
                check("midrst_rf_data", rf_data, 0);
                check("midrst_grant_id", grant_id, 0);
                check("midrst_req_ready", req_ready, 0);
                check("midrst_stall", stall, 0);
                @(posedge Clk);
                @(negedge Clk);
                model_reset();
                Rst_n = 1'b1;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && ($urandom % 2 == 0)) begin
                    pend[i] = 1'b1;
                    prd[i] = ($urandom % 8 == 0) ? '0 : AW'($urandom_range(1, NR - 1));
                    pdata[i] = $urandom;
                end
                req_valid[i] = pend[i];
                req_rd[i*AW +: AW] = prd[i];
                req_data[i*XLEN +: XLEN] = pdata[i];
            end
            issue_valid = ($urandom % 3 == 0);
            issue_rd = AW'($urandom_range(0, NR - 1));
            rs1 = AW'($urandom_range(0, NR - 1));
            rs2 = AW'($urandom_range(0, NR - 1));
            step();
            if (m_last_g >= 0) pend[m_last_g] = 1'b0;
        end

        idle();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
